// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller.
package irq_ctrl_pkg;

   // Config/status register map
   typedef enum logic [1:0] {
      IRQC_ADDR_ENABLE  = 2'd0,
      IRQC_ADDR_EDGE    = 2'd1,
      IRQC_ADDR_PENDING = 2'd2,
      IRQC_ADDR_STATUS  = 2'd3
   } irqc_addr_e;

   localparam int unsigned IRQC_STATUS_UNF_BIT    = 8;
   localparam int unsigned IRQC_STATUS_DESYNC_BIT = 9;

   localparam logic [15:0] CPU_IRQ_VEC_BASE = 16'h0020;

   // Handler address of source idx; 16-bit arithmetic wraps by design
   function automatic logic [15:0] irqc_vector(input logic [15:0] base,
                                               input logic [15:0] stride,
                                               input logic [3:0]  idx);
      return base + stride * {12'h000, idx};
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder (index 0 = highest priority).
module irq_prio_enc #(
   parameter int unsigned N_SRC = 8
) (
   input  logic [N_SRC-1:0] i_req,
   output logic [3:0]       o_idx,
   output logic             o_valid
);

   // Scan from the top so the lowest set index is the last one written
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int unsigned i = N_SRC; i > 0; i--) begin
         if (i_req[i-1]) begin
            o_valid = 1'b1;
            o_idx   = 4'(i - 1);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending capture, priority selection, nesting stack
// mirroring the cpu IRQ depth, and a small config/status register port.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC      = 8,
   parameter int unsigned NEST_DEPTH = 3,
   parameter logic [15:0] VEC_BASE   = CPU_IRQ_VEC_BASE,
   parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_SRC-1:0] i_irq_src,
   input  logic             i_int_en,
   input  logic             i_in_irq,
   input  logic             i_iret_detected,
   output logic             o_irq_take,
   output logic [15:0]      o_irq_vector,
   output logic [1:0]       o_depth,
   output logic [3:0]       o_active_idx,
   input  logic             i_cfg_we,
   input  logic [1:0]       i_cfg_addr,
   input  logic [15:0]      i_cfg_wdata,
   output logic [15:0]      o_cfg_rdata
);

   logic [N_SRC-1:0] enable_q, enable_d;
   logic [N_SRC-1:0] edge_q, edge_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] src_prev_q, src_prev_d;
   logic [3:0]       stack_q [NEST_DEPTH];
   logic [3:0]       stack_d [NEST_DEPTH];
   logic [1:0]       depth_q, depth_d;
   logic             irq_take_q, irq_take_d;
   logic [15:0]      irq_vector_q, irq_vector_d;
   logic             unf_q, unf_d;
   logic             desync_q, desync_d;
   logic             mismatch_q, mismatch_d;

   irqc_addr_e       cfg_addr;
   logic             status_wr;
   logic [N_SRC-1:0] wdata_src;
   logic [N_SRC-1:0] w1c_mask;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] take_clr;
   logic [3:0]       cand_idx;
   logic             cand_valid;
   logic [3:0]       top_idx;
   logic             take_ok;
   logic             unused_cfg_wdata;

   assign cfg_addr         = irqc_addr_e'(i_cfg_addr);
   assign status_wr        = i_cfg_we && (cfg_addr == IRQC_ADDR_STATUS);
   assign wdata_src        = i_cfg_wdata[N_SRC-1:0];
   assign unused_cfg_wdata = ^i_cfg_wdata;

   irq_prio_enc #(
      .N_SRC (N_SRC)
   ) u_prio_enc (
      .i_req   (pending_q & enable_q),
      .o_idx   (cand_idx),
      .o_valid (cand_valid)
   );

   // Source index at the top of the stack; 0 when nothing is active
   always_comb begin
      top_idx = '0;
      for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
         if (depth_q == 2'(i + 1)) begin
            top_idx = stack_q[i];
         end
      end
   end

   // An IRET in the same cycle always defers a take so the pop lands first
   assign take_ok = cand_valid && i_int_en &&
                    (depth_q < 2'(NEST_DEPTH)) &&
                    ((depth_q == 2'd0) || (cand_idx < top_idx)) &&
                    !irq_take_q && !i_iret_detected;

   // Next-state for pending, config, stack, take outputs and sticky flags
   always_comb begin
      rise     = i_irq_src & ~src_prev_q;
      w1c_mask = (i_cfg_we && (cfg_addr == IRQC_ADDR_PENDING)) ? wdata_src : '0;
      take_clr = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         take_clr[k] = take_ok && (cand_idx == 4'(k));
      end

      // Edge mode: a fresh rising edge beats both W1C and take-clear
      pending_d  = (edge_q & ((pending_q & ~w1c_mask & ~take_clr) | rise)) |
                   (~edge_q & i_irq_src);
      src_prev_d = i_irq_src;

      enable_d = enable_q;
      edge_d   = edge_q;
      if (i_cfg_we && (cfg_addr == IRQC_ADDR_ENABLE)) enable_d = wdata_src;
      if (i_cfg_we && (cfg_addr == IRQC_ADDR_EDGE))   edge_d   = wdata_src;

      stack_d = stack_q;
      depth_d = depth_q;
      if (i_iret_detected) begin
         if (depth_q != 2'd0) depth_d = depth_q - 2'd1;
      end else if (take_ok) begin
         for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
            if (depth_q == 2'(i)) stack_d[i] = cand_idx;
         end
         depth_d = depth_q + 2'd1;
      end

      irq_take_d   = take_ok;
      irq_vector_d = take_ok ? irqc_vector(VEC_BASE, VEC_STRIDE, cand_idx)
                             : irq_vector_q;

      unf_d      = (unf_q && !status_wr) || (i_iret_detected && (depth_q == 2'd0));
      mismatch_d = ((depth_q != 2'd0) != i_in_irq);
      desync_d   = (desync_q && !status_wr) || (mismatch_d && mismatch_q);
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         enable_q     <= '0;
         edge_q       <= '0;
         pending_q    <= '0;
         src_prev_q   <= '0;
         for (int unsigned i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
         depth_q      <= '0;
         irq_take_q   <= 1'b0;
         irq_vector_q <= '0;
         unf_q        <= 1'b0;
         desync_q     <= 1'b0;
         mismatch_q   <= 1'b0;
      end else begin
         enable_q     <= enable_d;
         edge_q       <= edge_d;
         pending_q    <= pending_d;
         src_prev_q   <= src_prev_d;
         stack_q      <= stack_d;
         depth_q      <= depth_d;
         irq_take_q   <= irq_take_d;
         irq_vector_q <= irq_vector_d;
         unf_q        <= unf_d;
         desync_q     <= desync_d;
         mismatch_q   <= mismatch_d;
      end
   end

   // Combinational read of the addressed config/status register
   always_comb begin
      o_cfg_rdata = '0;
      case (cfg_addr)
         IRQC_ADDR_ENABLE:  o_cfg_rdata = 16'(enable_q);
         IRQC_ADDR_EDGE:    o_cfg_rdata = 16'(edge_q);
         IRQC_ADDR_PENDING: o_cfg_rdata = 16'(pending_q);
         IRQC_ADDR_STATUS: begin
            o_cfg_rdata[1:0]                    = depth_q;
            o_cfg_rdata[7:4]                    = top_idx;
            o_cfg_rdata[IRQC_STATUS_UNF_BIT]    = unf_q;
            o_cfg_rdata[IRQC_STATUS_DESYNC_BIT] = desync_q;
         end
         default: o_cfg_rdata = '0;
      endcase
   end

   assign o_irq_take   = irq_take_q;
   assign o_irq_vector = irq_vector_q;
   assign o_depth      = depth_q;
   assign o_active_idx = top_idx;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: cycle model (queue-based stack) checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  src = '0;
   logic        int_en = 1'b0;
   logic        in_irq = 1'b0;
   logic        iret = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd3;
   logic [15:0] cfg_wdata = '0;

   logic        take;
   logic [15:0] vec;
   logic [1:0]  depth;
   logic [3:0]  aidx;
   logic [15:0] rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   irq_ctrl #(
      .N_SRC      (8),
      .NEST_DEPTH (3),
      .VEC_BASE   (16'h0020),
      .VEC_STRIDE (16'h0010)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_irq_src       (src),
      .i_int_en        (int_en),
      .i_in_irq        (in_irq),
      .i_iret_detected (iret),
      .o_irq_take      (take),
      .o_irq_vector    (vec),
      .o_depth         (depth),
      .o_active_idx    (aidx),
      .i_cfg_we        (cfg_we),
      .i_cfg_addr      (cfg_addr),
      .i_cfg_wdata     (cfg_wdata),
      .o_cfg_rdata     (rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  m_en = '0, m_edge = '0, m_pend = '0, m_prev = '0;
   int          m_stk[$];
   bit          m_take = 0;
   logic [15:0] m_vec = '0;
   bit          m_unf = 0, m_desync = 0, m_mis_prev = 0;

   int          mc;
   bit          mfound, melig, mmis, mclr;
   logic [7:0]  mnp;

   function automatic logic [3:0] m_top();
      return (m_stk.size() != 0) ? 4'(m_stk[$]) : 4'd0;
   endfunction

   function automatic logic [15:0] m_rd(input logic [1:0] a);
      logic [15:0] r;
      r = '0;
      case (a)
         2'd0: r = {8'h00, m_en};
         2'd1: r = {8'h00, m_edge};
         2'd2: r = {8'h00, m_pend};
         default: begin
            r[1:0] = 2'(m_stk.size());
            r[7:4] = m_top();
            r[8]   = m_unf;
            r[9]   = m_desync;
         end
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_en = '0; m_edge = '0; m_pend = '0; m_prev = '0;
         m_stk.delete();
         m_take = 0; m_vec = '0; m_unf = 0; m_desync = 0; m_mis_prev = 0;
      end else begin
         mfound = 0; mc = 0;
         for (int k = 0; k < 8; k++)
            if (!mfound && m_pend[k] && m_en[k]) begin mfound = 1; mc = k; end
         melig = mfound && int_en && (m_stk.size() < 3) &&
                 (m_stk.size() == 0 || mc < m_stk[$]) && !m_take && !iret;
         for (int k = 0; k < 8; k++) begin
            if (m_edge[k]) begin
               mnp[k] = m_pend[k];
               if (cfg_we && cfg_addr == 2'd2 && cfg_wdata[k]) mnp[k] = 1'b0;
               if (melig && mc == k) mnp[k] = 1'b0;
               if (src[k] && !m_prev[k]) mnp[k] = 1'b1;
            end else begin
               mnp[k] = src[k];
            end
         end
         mmis = ((m_stk.size() != 0) != in_irq);
         mclr = cfg_we && cfg_addr == 2'd3;
         m_unf    = (m_unf && !mclr) || (iret && m_stk.size() == 0);
         m_desync = (m_desync && !mclr) || (mmis && m_mis_prev);
         m_mis_prev = mmis;
         if (iret) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
         end else if (melig) begin
            m_stk.push_back(mc);
         end
         m_take = melig;
         if (melig) m_vec = 16'h0020 + 16'(mc) * 16'h0010;
         m_prev = src;
         m_pend = mnp;
         if (cfg_we && cfg_addr == 2'd0) m_en   = cfg_wdata[7:0];
         if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata[7:0];
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_take",  32'(take),  32'(m_take));
         chk("cyc_vec",   32'(vec),   32'(m_vec));
         chk("cyc_depth", 32'(depth), 32'(m_stk.size()));
         chk("cyc_aidx",  32'(aidx),  32'(m_top()));
         chk("cyc_rdata", 32'(rdata), 32'(m_rd(cfg_addr)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      cyc(1);
      cfg_we = 1'b0; cfg_addr = 2'd3; cfg_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [15:0] d);
      cfg_addr = a;
      #1;
      d = rdata;
      cfg_addr = 2'd3;
   endtask

   task automatic pulse_iret();
      iret = 1'b1;
      cyc(1);
      iret = 1'b0;
   endtask

   task automatic wait_take(input int maxc, output int n);
      n = 0;
      while (!take && n < maxc) begin
         cyc(1);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [15:0] d;
   int          n;

   initial begin
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      chk("rst_take", 32'(take), 0);
      chk("rst_vec", 32'(vec), 0);
      chk("rst_depth", 32'(depth), 0);
      chk("rst_aidx", 32'(aidx), 0);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         chk("rst_reg", 32'(d), 0);
      end

      // T1 underflow
      repeat (3) begin pulse_iret(); cyc(1); end
      chk("t1_depth", 32'(depth), 0);
      chk("t1_take", 32'(take), 0);
      rd(2'd3, d); chk("t1_status_unf", 32'(d), 32'h0100);
      cfg_write(2'd3, 16'hFFFF);
      rd(2'd3, d); chk("t1_status_clr", 32'(d), 32'h0000);

      // T2 single take
      cfg_write(2'd0, 16'h0001);
      cfg_write(2'd1, 16'h0001);
      int_en = 1'b1;
      src[0] = 1'b1;
      cyc(1);
      chk("t2_take_early", 32'(take), 0);
      rd(2'd2, d); chk("t2_pend_set", 32'(d), 32'h0001);
      cyc(1);
      chk("t2_take", 32'(take), 1);
      chk("t2_vec", 32'(vec), 32'h0020);
      chk("t2_depth", 32'(depth), 1);
      rd(2'd2, d); chk("t2_pend_clr", 32'(d), 32'h0000);
      src = '0;
      cyc(1);
      chk("t2_take_once", 32'(take), 0);
      chk("t2_vec_hold", 32'(vec), 32'h0020);
      cyc(1);
      rd(2'd3, d); chk("t2_status_desync", 32'(d), 32'h0201);
      pulse_iret();
      chk("t2_pop", 32'(depth), 0);
      cfg_write(2'd3, 16'h0000);

      // T3 nesting
      cfg_write(2'd0, 16'h000A);
      cfg_write(2'd1, 16'h000A);
      src[3] = 1'b1;
      cyc(2);
      chk("t3_take_a", 32'(take), 1);
      chk("t3_vec_a", 32'(vec), 32'h0050);
      chk("t3_aidx_a", 32'(aidx), 3);
      src[1] = 1'b1;
      cyc(2);
      chk("t3_take_b", 32'(take), 1);
      chk("t3_vec_b", 32'(vec), 32'h0030);
      chk("t3_depth_b", 32'(depth), 2);
      chk("t3_aidx_b", 32'(aidx), 1);
      src = '0;
      cyc(1);
      pulse_iret();
      chk("t3_pop1_depth", 32'(depth), 1);
      chk("t3_pop1_aidx", 32'(aidx), 3);
      pulse_iret();
      chk("t3_pop2_depth", 32'(depth), 0);
      chk("t3_pop2_aidx", 32'(aidx), 0);

      // T4 priority block
      cfg_write(2'd0, 16'h0022);
      cfg_write(2'd1, 16'h0022);
      src[1] = 1'b1;
      cyc(2);
      chk("t4_take_1", 32'(aidx), 1);
      src[5] = 1'b1;
      cyc(4);
      chk("t4_blocked", 32'(take), 0);
      chk("t4_depth", 32'(depth), 1);
      rd(2'd2, d); chk("t4_pend5", 32'(d), 32'h0020);
      src = '0;
      pulse_iret();
      chk("t4_pop", 32'(depth), 0);
      chk("t4_no_take_yet", 32'(take), 0);
      cyc(1);
      chk("t4_take_5", 32'(take), 1);
      chk("t4_vec_5", 32'(vec), 32'h0070);
      chk("t4_aidx_5", 32'(aidx), 5);
      cyc(1);
      pulse_iret();
      chk("t4_end", 32'(depth), 0);

      // T5 simultaneous iret/cand, int_en gating
      cfg_write(2'd0, 16'h0005);
      cfg_write(2'd1, 16'h0005);
      src[2] = 1'b1;
      cyc(2);
      chk("t5_vec_2", 32'(vec), 32'h0040);
      int_en = 1'b0;
      src[0] = 1'b1;
      cyc(4);
      chk("t5_gated", 32'(take), 0);
      rd(2'd2, d); chk("t5_pend_kept", 32'(d), 32'h0001);
      src = '0;
      int_en = 1'b1;
      pulse_iret();
      chk("t5_pop_first", 32'(depth), 0);
      chk("t5_no_take", 32'(take), 0);
      cyc(1);
      chk("t5_take", 32'(take), 1);
      chk("t5_vec_0", 32'(vec), 32'h0020);
      chk("t5_aidx_0", 32'(aidx), 0);
      cyc(1);
      pulse_iret();

      // T6 saturation and reset mid-handler
      cfg_write(2'd0, 16'h00FF);
      cfg_write(2'd1, 16'h00FF);
      for (int k = 7; k >= 5; k--) begin
         src[k] = 1'b1;
         wait_take(8, n);
         chk("t6_take_seen", 32'(n < 8), 1);
         cyc(1);
      end
      chk("t6_depth_full", 32'(depth), 3);
      chk("t6_aidx", 32'(aidx), 5);
      src[0] = 1'b1;
      cyc(4);
      chk("t6_sat_no_take", 32'(take), 0);
      rd(2'd2, d); chk("t6_pend0", 32'(d), 32'h0001);
      rst = 1'b1;
      cyc(1);
      chk("t6_rst_depth", 32'(depth), 0);
      chk("t6_rst_take", 32'(take), 0);
      rst = 1'b0;
      rd(2'd0, d); chk("t6_rst_enable", 32'(d), 0);
      src = '0;
      cyc(1);

      // T7 level mode and W1C vs new edge
      cfg_write(2'd0, 16'h0010);
      int_en = 1'b0;
      src[4] = 1'b1;
      cyc(1);
      rd(2'd2, d); chk("t7_level_hi", 32'(d), 32'h0010);
      src[4] = 1'b0;
      cyc(1);
      rd(2'd2, d); chk("t7_level_lo", 32'(d), 32'h0000);
      cfg_write(2'd1, 16'h0008);
      src[3] = 1'b1;
      cyc(1);
      rd(2'd2, d); chk("t7_edge_set", 32'(d), 32'h0008);
      cfg_write(2'd2, 16'h0008);
      rd(2'd2, d); chk("t7_w1c", 32'(d), 32'h0000);
      src[3] = 1'b0;
      cyc(1);
      src[3] = 1'b1;
      cfg_write(2'd2, 16'h0008);
      rd(2'd2, d); chk("t7_edge_wins", 32'(d), 32'h0008);
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
